// File: rtl/spi_flash_model.sv
// Behavioural SPI NOR-flash slave: oversampled mode-0 pins, 0x03 READ with a 24-bit address,
// bytes streamed MSB-first from a little-endian word array preloaded through a backdoor port.
module spi_flash_model #(
  parameter int MEM_BYTES = 16777216,
  parameter int SS_IDX    = 0,
  parameter int SS_NUM    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic [SS_NUM-1:0] spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              bd_we,
  input  logic [31:0]       bd_addr,
  input  logic [31:0]       bd_wdata,
  output logic              busy,
  output logic              bad_cmd
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int WAW   = (AW > 2) ? AW - 2 : 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  logic [2:0]  sck_q;
  logic [1:0]  ss_q;
  logic [1:0]  mosi_q;
  logic        ss_s, mosi_s, rise, fall;

  state_t      state_q;
  logic [4:0]  bitcnt_q;
  logic [7:0]  cmd_q;
  logic [23:0] addr_q;
  logic [7:0]  data_sr_q;
  logic        miso_q, busy_q, bad_cmd_q, armed_q;

  logic [31:0] mem_q [WORDS];

  logic [7:0]     cmd_d;
  logic [23:0]    addr_d, fetch_addr;
  logic [WAW-1:0] fetch_widx;
  logic [1:0]     fetch_lane;
  logic [31:0]    fetch_word;
  logic [7:0]     fetch_byte;
  logic           unused_ss;

  assign unused_ss = ^spi_ss;

  // Synchronisers are deliberately not reset so a low ss held across reset is still seen as low.
  always_ff @(posedge clock) begin
    sck_q  <= {sck_q[1:0], spi_sck};
    ss_q   <= {ss_q[0], spi_ss[SS_IDX]};
    mosi_q <= {mosi_q[0], spi_mosi};
  end

  assign ss_s   = ss_q[1];
  assign mosi_s = mosi_q[1];
  assign rise   = sck_q[1] & ~sck_q[2];
  assign fall   = ~sck_q[1] & sck_q[2];

  always_ff @(posedge clock) begin
    if (bd_we) begin
      mem_q[WAW'(bd_addr & 32'(WORDS - 1))] <= bd_wdata;
    end
  end

  always_comb begin
    cmd_d      = {cmd_q[6:0], mosi_s};
    addr_d     = {addr_q[22:0], mosi_s};
    fetch_addr = (state_q == ADDR) ? addr_d : addr_q + 24'd1;
    fetch_widx = WAW'((fetch_addr >> 2) & 24'(WORDS - 1));
    fetch_lane = fetch_addr[1:0];
    fetch_word = mem_q[fetch_widx];
    fetch_byte = fetch_word[{fetch_lane, 3'b000} +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_sr_q <= '0;
      miso_q    <= 1'b1;
      busy_q    <= 1'b0;
      bad_cmd_q <= 1'b0;
      armed_q   <= 1'b0;
    end else if (ss_s) begin
      // Deselect outranks any sck edge seen in the same cycle.
      state_q  <= IDLE;
      bitcnt_q <= '0;
      miso_q   <= 1'b1;
      busy_q   <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_q  <= CMD;
            bitcnt_q <= '0;
            busy_q   <= 1'b1;
            armed_q  <= 1'b0;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_q    <= cmd_d;
            bitcnt_q <= bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_q <= '0;
              if (cmd_d == 8'h03) begin
                state_q <= ADDR;
              end else begin
                state_q   <= IGNORE;
                bad_cmd_q <= 1'b1;
              end
            end
          end
        end
        ADDR: begin
          if (rise) begin
            addr_q   <= addr_d;
            bitcnt_q <= bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              bitcnt_q  <= '0;
              data_sr_q <= fetch_byte;
              state_q   <= DATA;
            end
          end
        end
        DATA: begin
          if (fall) begin
            miso_q <= data_sr_q[7];
            if (bitcnt_q == 5'd7) begin
              bitcnt_q  <= '0;
              addr_q    <= addr_q + 24'd1;
              data_sr_q <= fetch_byte;
            end else begin
              bitcnt_q  <= bitcnt_q + 5'd1;
              data_sr_q <= {data_sr_q[6:0], 1'b0};
            end
          end
        end
        IGNORE: begin
          miso_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign busy     = busy_q;
  assign bad_cmd  = bad_cmd_q;

endmodule

// File: tb/tb_spi_flash_model.sv
// Randomised bench for spi_flash_model: a byte-array reference model feeds a scoreboard queue,
// and a pin-level monitor reassembles MISO bytes and compares them as they appear.
module tb_spi_flash_model;
  localparam int MEM_BYTES = 1024;
  localparam int WORDS     = MEM_BYTES / 4;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        spi_sck  = 1'b0;
  logic [7:0]  spi_ss   = 8'hFF;
  logic        spi_mosi = 1'b0;
  logic        bd_we    = 1'b0;
  logic [31:0] bd_addr  = '0;
  logic [31:0] bd_wdata = '0;
  logic        spi_miso, busy, bad_cmd;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl [MEM_BYTES];
  logic [7:0] exp_q [$];
  logic       bad_exp = 1'b0;

  logic       mon_pk = 1'b0;
  int         mon_rises = 0;
  int         mon_nb = 0;
  logic [7:0] mon_cmd = '0;
  logic [7:0] mon_rx = '0;

  spi_flash_model #(.MEM_BYTES(MEM_BYTES), .SS_IDX(0), .SS_NUM(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .busy     (busy),
    .bad_cmd  (bad_cmd)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bd_write(input int w, input logic [31:0] d);
    @(negedge clock);
    bd_we    = 1'b1;
    bd_addr  = 32'(w);
    bd_wdata = d;
    for (int b = 0; b < 4; b++) mdl[(4 * w + b) % MEM_BYTES] = d[8 * b +: 8];
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic sck_bit(input logic b);
    spi_mosi = b;
    repeat (4) @(negedge clock);
    spi_sck = 1'b1;
    repeat (4) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sck_bit(v[i]);
  endtask

  task automatic clock_bits(input int n);
    for (int i = 0; i < n; i++) sck_bit(1'b0);
  endtask

  task automatic ss_lo();
    @(negedge clock);
    spi_ss[0] = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic ss_hi();
    repeat (4) @(negedge clock);
    spi_ss[0] = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic push_read(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mdl[(int'(a) + i) % MEM_BYTES]);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    push_read(a, n);
    ss_lo();
    send({8'h03, a}, 32);
    clock_bits(8 * n);
    ss_hi();
  endtask

  task automatic do_bad(input logic [7:0] c, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(8'hFF);
    bad_exp = 1'b1;
    ss_lo();
    send({24'h0, c}, 8);
    clock_bits(8 * nbytes);
    ss_hi();
  endtask

  // Monitor: counts sck rises per selection, decodes the command from MOSI and
  // collects every full byte after the command (bad) or command+address (read).
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (spi_ss[0]) begin
        mon_rises = 0;
        mon_nb    = 0;
      end else if (spi_sck && !mon_pk) begin
        mon_rises++;
        if (mon_rises <= 8) begin
          mon_cmd = {mon_cmd[6:0], spi_mosi};
        end else if (mon_rises > ((mon_cmd == 8'h03) ? 32 : 8)) begin
          mon_rx = {mon_rx[6:0], spi_miso};
          mon_nb++;
          if (mon_nb == 8) begin
            mon_nb = 0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_byte: got %h expected none", mon_rx);
            end else begin
              check("miso_byte", {24'h0, mon_rx}, {24'h0, exp_q.pop_front()});
            end
          end
        end
      end
      mon_pk = spi_sck;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] ra;
    logic [7:0]  rc;

    // Backdoor preload while reset is held: random fill, then the fixed words.
    for (int w = 0; w < WORDS; w++) bd_write(w, $urandom);
    bd_write(0, 32'h44332211);
    bd_write(1, 32'h88776655);
    bd_write(WORDS - 1, 32'hDDCCBBAA);
    @(negedge clock);
    check("reset_miso", {31'h0, spi_miso}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_bad_cmd", {31'h0, bad_cmd}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Full 8-byte read from 0 with busy timing around deselect.
    push_read(24'h0, 8);
    ss_lo();
    send({8'h03, 24'h000000}, 32);
    clock_bits(64);
    check("busy_during_read", {31'h0, busy}, 32'h1);
    repeat (4) @(negedge clock);
    spi_ss[0] = 1'b1;
    @(negedge clock);
    check("busy_1clk_after_ss_high", {31'h0, busy}, 32'h1);
    repeat (2) @(negedge clock);
    check("busy_3clk_after_ss_high", {31'h0, busy}, 32'h0);
    check("miso_idle_after_read", {31'h0, spi_miso}, 32'h1);
    repeat (8) @(negedge clock);

    do_read(24'h000006, 4);
    do_read(24'h0003FE, 4);

    do_bad(8'h9F, 4);
    check("bad_cmd_sticky", {31'h0, bad_cmd}, 32'h1);
    do_read(24'h000010, 3);
    check("bad_cmd_after_good_read", {31'h0, bad_cmd}, 32'h1);

    // Abort after 12 address bits, then a clean read.
    ss_lo();
    send(32'h03, 8);
    send(32'h0, 12);
    ss_hi();
    check("busy_after_abort", {31'h0, busy}, 32'h0);
    do_read(24'h000004, 2);

    // Reset pulse in the DATA phase with ss held low: remaining bytes read as FF.
    push_read(24'h000020, 2);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    ss_lo();
    send({8'h03, 24'h000020}, 32);
    clock_bits(16);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bad_exp = 1'b0;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_miso", {31'h0, spi_miso}, 32'h1);
    check("midreset_bad_cmd", {31'h0, bad_cmd}, 32'h0);
    clock_bits(16);
    check("midreset_busy_stays_low", {31'h0, busy}, 32'h0);
    ss_hi();
    do_read(24'h000000, 8);

    // Randomised traffic: aliased 24-bit addresses, bad commands, backdoor updates.
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        rc = 8'($urandom_range(0, 255));
        if (rc == 8'h03) rc = 8'hAB;
        do_bad(rc, $urandom_range(1, 3));
      end else begin
        if ($urandom_range(0, 1) == 1) bd_write($urandom_range(0, WORDS - 1), $urandom);
        ra = 24'($urandom);
        if ($urandom_range(0, 2) == 0) ra[9:0] = 10'($urandom_range(MEM_BYTES - 4, MEM_BYTES - 1));
        do_read(ra, $urandom_range(1, 5));
      end
    end

    check("bad_cmd_final", {31'h0, bad_cmd}, {31'h0, bad_exp});
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
